i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) with a small byte register bank: the far end of the I2C master link used by our
//  screen driver. Lets an external I2C master (or a second board) write/read registers that the CPU also
//  reads/writes over the data bus, giving a memory-mapped mailbox beside the button and screen peripherals.
// PARAMETERS
//  DEV_ADDR   7'h3C  7-bit I2C address this target answers to
//  NUM_REGS   16     register count, power of two, 2..256
//  ADDR_W     4      log2(NUM_REGS); register pointer / CPU address width
// PORTS
//  clk           in   1       system clock; must be >= 8x SCL rate
//  reset         in   1       asynchronous, active-high
//  scl_in        in   1       SCL from pad (async)
//  sda_in        in   1       SDA from pad (async)
//  sda_oe        out  1       1 = pull SDA low (open drain); pad releases SDA when 0
//  cpu_addr      in   ADDR_W  CPU register index
//  cpu_wen       in   1       CPU write strobe, one clk
//  cpu_wdata     in   8       CPU write data
//  cpu_rdata     out  8       regs[cpu_addr], registered, 1-clk latency
//  i2c_wr_pulse  out  1       1-clk pulse when I2C master commits a data byte
//  i2c_wr_addr   out  ADDR_W  register index of that byte; valid with i2c_wr_pulse
//  busy          out  1       1 from addressed START to STOP / NACK / mismatch
// BEHAVIOUR
//  Reset: sda_oe=0, cpu_rdata=0, i2c_wr_pulse=0, i2c_wr_addr=0, busy=0, all regs=0, ptr=0, state=IDLE.
//  Input path: scl_in/sda_in pass 2-FF synchronisers plus one history FF; edges/conditions from sync'd copies.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both act from every state, same clk.
//  START (incl. repeated) -> ADDR, bit count 0, sda_oe=0. STOP -> IDLE, busy=0, sda_oe=0. ptr kept.
//  Data bits sampled on SCL rise, MSB first; sda_oe changes only on the clk after SCL fall is detected.
//  States:
//   IDLE       wait for START.
//   ADDR       shift 8 bits (7 addr + R/W). On 8th SCL fall: match -> ADDR_ACK (sda_oe=1, busy=1);
//              mismatch -> IDLE (no ACK, ignore bus until next START).
//   ADDR_ACK   hold ACK through one SCL pulse; at its fall: W -> PTR, sda_oe=0; R -> RDATA, load shifter
//              with regs[ptr], drive bit7 (sda_oe = ~bit).
//   PTR        shift 8 bits; at 8th fall ptr <= byte[ADDR_W-1:0] (upper bits ignored), ACK -> PTR_ACK.
//   PTR_ACK    after ACK pulse -> WDATA.
//   WDATA      shift 8 bits; at 8th fall: regs[ptr] <= byte, i2c_wr_pulse=1, i2c_wr_addr=ptr,
//              ptr <= ptr+1 mod NUM_REGS, ACK -> WDATA_ACK.
//   WDATA_ACK  after ACK pulse -> WDATA (always ACK; no overflow NACK).
//   RDATA      drive bits 7..0, each updated on SCL fall; after 8th fall sda_oe=0, ptr <= ptr+1 mod
//              NUM_REGS -> RACK.
//   RACK       sample master ACK on SCL rise: ACK(0) -> at fall load regs[ptr], RDATA; NACK(1) -> IDLE.
//  Wrap: ptr NUM_REGS-1 increments to 0 on both read and write.
//  Collision: CPU write and I2C commit same clk same reg -> CPU value wins, i2c_wr_pulse still asserted.
//  Read shifter loads a snapshot; later writes to that reg do not affect the byte in flight.
//  cpu_rdata reflects writes from the previous clk (no write-through bypass).
//  Reset mid-transfer: immediate return to reset values, SDA released asynchronously.
//  Glitch on SCL shorter than 2 clk not filtered beyond synchroniser; spec requires clean bus.
// TESTING
//  START, 0x78(W), 0x03, 0xA5, 0x5A, STOP -> three ACKs, regs[3]=A5, regs[4]=5A, two i2c_wr_pulse (addr 3,4).
//  START, 0x78, 0x02, Sr, 0x79, read 2 bytes ACK then NACK, STOP -> ACKs, bytes regs[2],regs[3]; ptr=4.
//  START, 0x50(W) -> no ACK (sda_oe stays 0), busy=0, following data bytes ignored, regs unchanged.
//  ptr=0x0F, write 0x11,0x22 -> regs[15]=11, regs[0]=22 (wrap); read from 15 returns regs[15],regs[0].
//  cpu_wen addr 5 data 0xEE same clk as I2C commit 0x33 to 5 -> regs[5]=EE; cpu_rdata=EE next clk.
//  reset asserted while target drives ACK -> sda_oe=0 same cycle; after release next START handled normally.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register bank shared with the CPU data bus.
// The I2C master sets a register pointer, then streams bytes in or out with auto-increment.
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int         NUM_REGS = 16,
   parameter int         ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wen,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              i2c_wr_pulse,
   output logic [ADDR_W-1:0] i2c_wr_addr,
   output logic              busy
);

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_PTR       = 4'd3;
   localparam logic [3:0] ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_RDATA     = 4'd7;
   localparam logic [3:0] ST_RACK      = 4'd8;

   logic              scl_sync1_r, scl_sync2_r, scl_prev_r;
   logic              sda_sync1_r, sda_sync2_r, sda_prev_r;
   logic              scl_rise_s, scl_fall_s, start_s, stop_s;
   logic              byte_done_s, commit_s;
   logic [3:0]        state_r;
   logic [3:0]        bit_cnt_r;
   logic [7:0]        shift_r;
   logic [ADDR_W-1:0] ptr_r;
   logic              rw_r;
   logic              master_nack_r;
   logic [7:0]        regs_r [NUM_REGS];

   // Two-flop synchronisers on both pad inputs plus one history flop for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync1_r <= 1'b1;
         scl_sync2_r <= 1'b1;
         scl_prev_r  <= 1'b1;
         sda_sync1_r <= 1'b1;
         sda_sync2_r <= 1'b1;
         sda_prev_r  <= 1'b1;
      end else begin
         scl_sync1_r <= scl_in;
         scl_sync2_r <= scl_sync1_r;
         scl_prev_r  <= scl_sync2_r;
         sda_sync1_r <= sda_in;
         sda_sync2_r <= sda_sync1_r;
         sda_prev_r  <= sda_sync2_r;
      end
   end

   assign scl_rise_s  = scl_sync2_r & ~scl_prev_r;
   assign scl_fall_s  = ~scl_sync2_r & scl_prev_r;
   assign start_s     = scl_sync2_r & scl_prev_r & sda_prev_r & ~sda_sync2_r;
   assign stop_s      = scl_sync2_r & scl_prev_r & ~sda_prev_r & sda_sync2_r;
   assign byte_done_s = scl_fall_s & (bit_cnt_r == 4'd8);
   assign commit_s    = (state_r == ST_WDATA) & byte_done_s & ~start_s & ~stop_s;

   // Protocol state machine: bus conditions override whatever the current state is doing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= 4'd0;
         shift_r       <= 8'd0;
         ptr_r         <= {ADDR_W{1'b0}};
         rw_r          <= 1'b0;
         master_nack_r <= 1'b0;
         sda_oe        <= 1'b0;
         busy          <= 1'b0;
         i2c_wr_pulse  <= 1'b0;
         i2c_wr_addr   <= {ADDR_W{1'b0}};
      end else begin
         i2c_wr_pulse <= 1'b0;
         if (start_s) begin
            state_r   <= ST_ADDR;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
         end else if (stop_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  sda_oe <= 1'b0;
               end
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (scl_rise_s) begin
                     shift_r   <= {shift_r[6:0], sda_sync2_r};
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end else if (byte_done_s) begin
                     bit_cnt_r <= 4'd0;
                     if (state_r == ST_ADDR) begin
                        if (shift_r[7:1] == DEV_ADDR) begin
                           rw_r    <= shift_r[0];
                           sda_oe  <= 1'b1;
                           busy    <= 1'b1;
                           state_r <= ST_ADDR_ACK;
                        end else begin
                           busy    <= 1'b0;
                           state_r <= ST_IDLE;
                        end
                     end else if (state_r == ST_PTR) begin
                        ptr_r   <= shift_r[ADDR_W-1:0];
                        sda_oe  <= 1'b1;
                        state_r <= ST_PTR_ACK;
                     end else begin
                        i2c_wr_pulse <= 1'b1;
                        i2c_wr_addr  <= ptr_r;
                        ptr_r        <= ptr_r + ADDR_W'(1);
                        sda_oe       <= 1'b1;
                        state_r      <= ST_WDATA_ACK;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall_s) begin
                     bit_cnt_r <= 4'd0;
                     if (rw_r) begin
                        // Snapshot the register so later writes cannot corrupt the byte in flight.
                        shift_r <= regs_r[ptr_r];
                        sda_oe  <= ~regs_r[ptr_r][7];
                        state_r <= ST_RDATA;
                     end else begin
                        sda_oe  <= 1'b0;
                        state_r <= ST_PTR;
                     end
                  end
               end
               ST_PTR_ACK, ST_WDATA_ACK: begin
                  if (scl_fall_s) begin
                     bit_cnt_r <= 4'd0;
                     sda_oe    <= 1'b0;
                     state_r   <= ST_WDATA;
                  end
               end
               ST_RDATA: begin
                  if (scl_fall_s) begin
                     if (bit_cnt_r == 4'd7) begin
                        bit_cnt_r <= 4'd0;
                        sda_oe    <= 1'b0;
                        ptr_r     <= ptr_r + ADDR_W'(1);
                        state_r   <= ST_RACK;
                     end else begin
                        shift_r   <= {shift_r[6:0], 1'b0};
                        sda_oe    <= ~shift_r[6];
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                     end
                  end
               end
               ST_RACK: begin
                  if (scl_rise_s) begin
                     master_nack_r <= sda_sync2_r;
                  end else if (scl_fall_s) begin
                     if (master_nack_r) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                     end else begin
                        shift_r   <= regs_r[ptr_r];
                        sda_oe    <= ~regs_r[ptr_r][7];
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_RDATA;
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  sda_oe  <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   // Register bank: a CPU write to the same register in the same clock beats the I2C commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cpu_wen && (cpu_addr == ADDR_W'(i))) begin
               regs_r[i] <= cpu_wdata;
            end else if (commit_s && (ptr_r == ADDR_W'(i))) begin
               regs_r[i] <= shift_r;
            end
         end
      end
   end

   // CPU read port, one clock of latency and no bypass of same-clock writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_rdata <= 8'd0;
      end else begin
         cpu_rdata <= regs_r[cpu_addr];
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bit-banged I2C master, CPU vector table,
// directed corner cases and randomized transactions against a register-array model.
module tb_i2c_target_regs;

   logic       clk;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [3:0] cpu_addr;
   logic       cpu_wen;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       i2c_wr_pulse;
   logic [3:0] i2c_wr_addr;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mdl_regs [16];
   int         mdl_ptr;
   logic [3:0] pulse_q [$];
   logic [3:0] exp_pulse_q [$];
   logic [7:0] wbuf [$];

   typedef struct {
      logic [3:0] addr;
      logic       wen;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } cpu_vec_t;

   cpu_vec_t vecs [8];

   i2c_target_regs #(.DEV_ADDR(7'h3C), .NUM_REGS(16), .ADDR_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .sda_oe       (sda_oe),
      .cpu_addr     (cpu_addr),
      .cpu_wen      (cpu_wen),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .i2c_wr_pulse (i2c_wr_pulse),
      .i2c_wr_addr  (i2c_wr_addr),
      .busy         (busy)
   );

   // Open-drain bus: either side can pull SDA low.
   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (i2c_wr_pulse) pulse_q.push_back(i2c_wr_addr);
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, output logic smp);
      sda_m = b;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(4);
      smp = sda_in;
      wait_clk(4);
      scl_m = 1'b0;
      wait_clk(4);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(8);
      sda_m = 1'b0;
      wait_clk(8);
      scl_m = 1'b0;
      wait_clk(4);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(8);
      sda_m = 1'b1;
      wait_clk(8);
   endtask

   // Byte from master; optional CPU write timed onto the same clock as the target's commit.
   task automatic write_byte(input logic [7:0] b, input logic collide,
                             input logic [3:0] c_addr, input logic [7:0] c_data,
                             output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && collide) begin
            sda_m = b[0];
            wait_clk(4);
            scl_m = 1'b1;
            wait_clk(8);
            scl_m = 1'b0;
            wait_clk(2);
            cpu_addr  = c_addr;
            cpu_wdata = c_data;
            cpu_wen   = 1'b1;
            wait_clk(1);
            cpu_wen = 1'b0;
            check("collide_pulse", {31'd0, i2c_wr_pulse}, 32'd1);
            check("collide_pulse_addr", {28'd0, i2c_wr_addr}, {28'd0, c_addr});
            wait_clk(1);
            check("collide_rdata", {24'd0, cpu_rdata}, {24'd0, c_data});
         end else begin
            send_bit(b[i], s);
         end
      end
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(nack, s);
   endtask

   task automatic cpu_read_check(input string name, input logic [3:0] a);
      cpu_addr = a;
      wait_clk(2);
      check(name, {24'd0, cpu_rdata}, {24'd0, mdl_regs[a]});
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wen   = 1'b1;
      wait_clk(1);
      cpu_wen = 1'b0;
      mdl_regs[a] = d;
   endtask

   task automatic check_pulses(input string name);
      check({name, "_count"}, pulse_q.size(), exp_pulse_q.size());
      if (pulse_q.size() == exp_pulse_q.size()) begin
         foreach (exp_pulse_q[k]) check({name, "_addr"}, {28'd0, pulse_q[k]}, {28'd0, exp_pulse_q[k]});
      end
      pulse_q.delete();
      exp_pulse_q.delete();
   endtask

   // Write transaction: set pointer p then stream wbuf; model advances pointer modulo 16.
   task automatic txn_write(input string name, input logic [3:0] p);
      logic ack;
      pulse_q.delete();
      exp_pulse_q.delete();
      i2c_start();
      write_byte(8'h78, 1'b0, 4'd0, 8'd0, ack);
      check({name, "_addr_ack"}, {31'd0, ack}, 32'd1);
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      write_byte({4'h0, p}, 1'b0, 4'd0, 8'd0, ack);
      check({name, "_ptr_ack"}, {31'd0, ack}, 32'd1);
      mdl_ptr = p;
      foreach (wbuf[k]) begin
         write_byte(wbuf[k], 1'b0, 4'd0, 8'd0, ack);
         check({name, "_data_ack"}, {31'd0, ack}, 32'd1);
         mdl_regs[mdl_ptr] = wbuf[k];
         exp_pulse_q.push_back(mdl_ptr[3:0]);
         mdl_ptr = (mdl_ptr + 1) % 16;
      end
      i2c_stop();
      check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      check_pulses(name);
   endtask

   // Read transaction of n bytes, optionally setting the pointer first via repeated START.
   task automatic txn_read(input string name, input logic set_ptr, input logic [3:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         write_byte(8'h78, 1'b0, 4'd0, 8'd0, ack);
         check({name, "_waddr_ack"}, {31'd0, ack}, 32'd1);
         write_byte({4'h0, p}, 1'b0, 4'd0, 8'd0, ack);
         check({name, "_ptr_ack"}, {31'd0, ack}, 32'd1);
         mdl_ptr = p;
         i2c_start();
      end
      write_byte(8'h79, 1'b0, 4'd0, 8'd0, ack);
      check({name, "_raddr_ack"}, {31'd0, ack}, 32'd1);
      for (int k = 0; k < n; k++) begin
         read_byte((k == n - 1), d);
         check({name, "_rbyte"}, {24'd0, d}, {24'd0, mdl_regs[mdl_ptr]});
         mdl_ptr = (mdl_ptr + 1) % 16;
      end
      check({name, "_busy_nack"}, {31'd0, busy}, 32'd0);
      i2c_stop();
   endtask

   initial begin
      logic ack;
      reset     = 1'b1;
      scl_m     = 1'b1;
      sda_m     = 1'b1;
      cpu_addr  = 4'd0;
      cpu_wen   = 1'b0;
      cpu_wdata = 8'd0;
      for (int i = 0; i < 16; i++) mdl_regs[i] = 8'd0;
      mdl_ptr = 0;

      vecs[0] = '{4'd0,  1'b0, 8'h00, 8'h00};
      vecs[1] = '{4'd1,  1'b1, 8'h11, 8'h00};
      vecs[2] = '{4'd1,  1'b0, 8'h00, 8'h11};
      vecs[3] = '{4'd15, 1'b1, 8'hF0, 8'h00};
      vecs[4] = '{4'd15, 1'b0, 8'h00, 8'hF0};
      vecs[5] = '{4'd1,  1'b1, 8'h22, 8'h11};
      vecs[6] = '{4'd1,  1'b0, 8'h00, 8'h22};
      vecs[7] = '{4'd0,  1'b0, 8'h00, 8'h00};

      wait_clk(3);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pulse", {31'd0, i2c_wr_pulse}, 32'd0);
      check("rst_wr_addr", {28'd0, i2c_wr_addr}, 32'd0);
      check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
      reset = 1'b0;
      wait_clk(2);

      // CPU port vectors: a write shows the old value, the following read shows the new one.
      for (int i = 0; i < 8; i++) begin
         cpu_addr  = vecs[i].addr;
         cpu_wen   = vecs[i].wen;
         cpu_wdata = vecs[i].wdata;
         wait_clk(1);
         check($sformatf("vec%0d_rdata", i), {24'd0, cpu_rdata}, {24'd0, vecs[i].exp_rdata});
         if (vecs[i].wen) mdl_regs[vecs[i].addr] = vecs[i].wdata;
         cpu_wen = 1'b0;
      end

      wbuf = '{8'hA5, 8'h5A};
      txn_write("wr_basic", 4'd3);
      cpu_read_check("wr_basic_reg3", 4'd3);
      cpu_read_check("wr_basic_reg4", 4'd4);

      txn_read("rd_basic", 1'b1, 4'd2, 2);
      txn_read("rd_ptr4", 1'b0, 4'd0, 1);

      // Wrong device address: no ACK, bus ignored until the next START.
      pulse_q.delete();
      i2c_start();
      write_byte(8'h50, 1'b0, 4'd0, 8'd0, ack);
      check("mis_ack", {31'd0, ack}, 32'd0);
      check("mis_busy", {31'd0, busy}, 32'd0);
      write_byte(8'h03, 1'b0, 4'd0, 8'd0, ack);
      check("mis_ack2", {31'd0, ack}, 32'd0);
      write_byte(8'h99, 1'b0, 4'd0, 8'd0, ack);
      check("mis_ack3", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("mis_pulses", pulse_q.size(), 32'd0);
      cpu_read_check("mis_reg3", 4'd3);

      wbuf = '{8'h11, 8'h22};
      txn_write("wrap_wr", 4'd15);
      cpu_read_check("wrap_reg15", 4'd15);
      cpu_read_check("wrap_reg0", 4'd0);
      txn_read("wrap_rd", 1'b1, 4'd15, 2);

      // CPU and I2C write register 5 on the same clock.
      cpu_write(4'd5, 8'h01);
      pulse_q.delete();
      i2c_start();
      write_byte(8'h78, 1'b0, 4'd0, 8'd0, ack);
      check("col_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h05, 1'b0, 4'd0, 8'd0, ack);
      write_byte(8'h33, 1'b1, 4'd5, 8'hEE, ack);
      check("col_data_ack", {31'd0, ack}, 32'd1);
      i2c_stop();
      mdl_regs[5] = 8'hEE;
      mdl_ptr = 6;
      cpu_read_check("col_reg5", 4'd5);
      pulse_q.delete();

      // Reset while the target holds the address ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic s;
         logic [7:0] a;
         a = 8'h78;
         if (i == 0) begin
            sda_m = a[0];
            wait_clk(4);
            scl_m = 1'b1;
            wait_clk(8);
            scl_m = 1'b0;
            wait_clk(5);
         end else begin
            send_bit(a[i], s);
         end
      end
      check("rst_mid_driving", {31'd0, sda_oe}, 32'd1);
      #2 reset = 1'b1;
      #1 check("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      wait_clk(3);
      reset = 1'b0;
      sda_m = 1'b1;
      for (int i = 0; i < 16; i++) mdl_regs[i] = 8'd0;
      mdl_ptr = 0;
      wait_clk(4);
      cpu_read_check("rst_mid_reg5", 4'd5);
      wbuf = '{8'h3C};
      txn_write("after_rst", 4'd7);
      cpu_read_check("after_rst_reg7", 4'd7);

      // Randomized traffic against the array model.
      for (int it = 0; it < 10; it++) begin
         int op;
         int n;
         op = $urandom_range(0, 2);
         n  = $urandom_range(1, 3);
         cpu_write(4'($urandom_range(0, 15)), 8'($urandom));
         if (op == 0) begin
            wbuf.delete();
            for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
            txn_write("rnd_wr", 4'($urandom_range(0, 15)));
         end else if (op == 1) begin
            txn_read("rnd_rd", 1'b1, 4'($urandom_range(0, 15)), n);
         end else begin
            txn_read("rnd_rd_cont", 1'b0, 4'd0, n);
         end
      end
      for (int i = 0; i < 16; i++) cpu_read_check("final_dump", 4'(i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
